// File: rtl/uart_nids_link_if.sv
// Byte-stream handshake bundle between the UART core and the NIDS link engine.
// The slave modport is the link engine's view; the master modport is the UART side.
`timescale 1ns/1ps

interface uart_nids_link_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );
endinterface

// File: rtl/uart_nids_link.sv
// Framed command/response engine: parses SYNC,CMD,ARG,CHK host frames from UART RX,
// drives labels to the NIDS core and emits ACK/NAK, ping and alert frames on UART TX.
`timescale 1ns/1ps

module uart_nids_link #(
   parameter int         TIMEOUT_CYC = 520_833,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   uart_nids_link_if.slave        io_bus,
   input  logic                   i_alert_in,
   input  logic [7:0]             i_alert_code,
   output logic [7:0]             o_label_out,
   output logic                   o_label_valid,
   output logic [7:0]             o_err_cnt
);

   localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

   localparam logic [7:0] CMD_LABEL = 8'h4C;
   localparam logic [7:0] CMD_PING  = 8'h50;
   localparam logic [7:0] CMD_ALERT = 8'h41;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;
   localparam logic [7:0] NAK_CHK   = 8'h01;
   localparam logic [7:0] NAK_CMD   = 8'h02;

   typedef enum logic [1:0] {
      RX_HUNT,
      RX_CMD,
      RX_ARG,
      RX_CHK
   } rxState_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_SYNC,
      TX_B1,
      TX_B2,
      TX_CHK
   } txState_t;

   rxState_t      r_rxState;
   rxState_t      w_rxNext;
   txState_t      r_txState;
   txState_t      w_txNext;

   logic          r_rxReady;
   logic [7:0]    r_cmd;
   logic [7:0]    r_arg;
   logic [CW-1:0] r_toCnt;

   logic          r_respFull;
   logic [7:0]    r_respB1;
   logic [7:0]    r_respB2;

   logic          r_alertQ;
   logic          r_alertPend;
   logic [7:0]    r_alertCode;

   logic [7:0]    r_txB1;
   logic [7:0]    r_txB2;

   logic [7:0]    r_labelOut;
   logic          r_labelValid;
   logic [7:0]    r_errCnt;

   logic          w_accept;
   logic          w_timeout;
   logic          w_frameDone;
   logic          w_chkOk;
   logic          w_respGen;
   logic [7:0]    w_respB1;
   logic [7:0]    w_respB2;
   logic          w_protoErr;
   logic          w_labelLoad;
   logic          w_respDrop;
   logic          w_alertEdge;
   logic          w_alertDrop;
   logic          w_alertTake;
   logic          w_respTake;
   logic          w_errEvent;
   logic [7:0]    w_txData;
   logic          w_txValid;

   assign w_accept    = io_bus.rx_valid & r_rxReady;
   assign w_frameDone = w_accept && (r_rxState == RX_CHK);
   assign w_timeout   = (r_rxState != RX_HUNT) && !w_accept && (r_toCnt == TO_LAST);

   // A slot being handed to TX in this very cycle counts as free for a new entry.
   assign w_respDrop  = w_respGen && r_respFull && !w_respTake;
   assign w_alertEdge = i_alert_in & ~r_alertQ;
   assign w_alertDrop = w_alertEdge && r_alertPend && !w_alertTake;
   assign w_errEvent  = w_protoErr | w_respDrop | w_timeout | w_alertDrop;

   // RX frame parser: next-state logic, one step per accepted byte
   always_comb begin
      w_rxNext = r_rxState;
      if (w_timeout) begin
         w_rxNext = RX_HUNT;
      end else if (w_accept) begin
         case (r_rxState)
            RX_HUNT: begin
               if (io_bus.rx_data == SYNC_BYTE) begin
                  w_rxNext = RX_CMD;
               end
            end
            RX_CMD:  w_rxNext = RX_ARG;
            RX_ARG:  w_rxNext = RX_CHK;
            RX_CHK:  w_rxNext = RX_HUNT;
            default: w_rxNext = RX_HUNT;
         endcase
      end
   end

   // Frame decode happens as the checksum byte is accepted
   always_comb begin
      w_chkOk     = (io_bus.rx_data == (SYNC_BYTE ^ r_cmd ^ r_arg));
      w_respGen   = 1'b0;
      w_respB1    = 8'h00;
      w_respB2    = 8'h00;
      w_protoErr  = 1'b0;
      w_labelLoad = 1'b0;
      if (w_frameDone) begin
         w_respGen = 1'b1;
         if (!w_chkOk) begin
            w_respB1   = RSP_NAK;
            w_respB2   = NAK_CHK;
            w_protoErr = 1'b1;
         end else if (r_cmd == CMD_LABEL) begin
            w_respB1    = RSP_ACK;
            w_respB2    = CMD_LABEL;
            w_labelLoad = 1'b1;
         end else if (r_cmd == CMD_PING) begin
            w_respB1 = CMD_PING;
            w_respB2 = r_arg;
         end else begin
            w_respB1   = RSP_NAK;
            w_respB2   = NAK_CMD;
            w_protoErr = 1'b1;
         end
      end
   end

   // TX framer: alert has priority over the response slot when leaving IDLE
   always_comb begin
      w_txNext    = r_txState;
      w_alertTake = 1'b0;
      w_respTake  = 1'b0;
      w_txData    = 8'h00;
      w_txValid   = 1'b0;
      case (r_txState)
         TX_IDLE: begin
            if (r_alertPend) begin
               w_alertTake = 1'b1;
               w_txNext    = TX_SYNC;
            end else if (r_respFull) begin
               w_respTake = 1'b1;
               w_txNext   = TX_SYNC;
            end
         end
         TX_SYNC: begin
            w_txValid = 1'b1;
            w_txData  = SYNC_BYTE;
            if (io_bus.tx_ready) w_txNext = TX_B1;
         end
         TX_B1: begin
            w_txValid = 1'b1;
            w_txData  = r_txB1;
            if (io_bus.tx_ready) w_txNext = TX_B2;
         end
         TX_B2: begin
            w_txValid = 1'b1;
            w_txData  = r_txB2;
            if (io_bus.tx_ready) w_txNext = TX_CHK;
         end
         TX_CHK: begin
            w_txValid = 1'b1;
            w_txData  = SYNC_BYTE ^ r_txB1 ^ r_txB2;
            if (io_bus.tx_ready) w_txNext = TX_IDLE;
         end
         default: w_txNext = TX_IDLE;
      endcase
   end

   // RX state, argument latches and inter-byte timeout counter
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rxState <= RX_HUNT;
         r_rxReady <= 1'b0;
         r_cmd     <= 8'h00;
         r_arg     <= 8'h00;
         r_toCnt   <= '0;
      end else begin
         r_rxState <= w_rxNext;
         r_rxReady <= 1'b1;
         if (w_accept && (r_rxState == RX_CMD)) r_cmd <= io_bus.rx_data;
         if (w_accept && (r_rxState == RX_ARG)) r_arg <= io_bus.rx_data;
         if (w_accept || w_timeout || (r_rxState == RX_HUNT)) begin
            r_toCnt <= '0;
         end else begin
            r_toCnt <= r_toCnt + CW'(1);
         end
      end
   end

   // Response and alert pending slots feeding the TX framer
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_respFull  <= 1'b0;
         r_respB1    <= 8'h00;
         r_respB2    <= 8'h00;
         r_alertQ    <= 1'b0;
         r_alertPend <= 1'b0;
         r_alertCode <= 8'h00;
      end else begin
         r_alertQ <= i_alert_in;
         if (w_respGen && !w_respDrop) begin
            r_respFull <= 1'b1;
            r_respB1   <= w_respB1;
            r_respB2   <= w_respB2;
         end else if (w_respTake) begin
            r_respFull <= 1'b0;
         end
         if (w_alertEdge && !w_alertDrop) begin
            r_alertPend <= 1'b1;
            r_alertCode <= i_alert_code;
         end else if (w_alertTake) begin
            r_alertPend <= 1'b0;
         end
      end
   end

   // TX state and the payload of the frame currently being sent
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_txState <= TX_IDLE;
         r_txB1    <= 8'h00;
         r_txB2    <= 8'h00;
      end else begin
         r_txState <= w_txNext;
         if (w_alertTake) begin
            r_txB1 <= CMD_ALERT;
            r_txB2 <= r_alertCode;
         end else if (w_respTake) begin
            r_txB1 <= r_respB1;
            r_txB2 <= r_respB2;
         end
      end
   end

   // Label output and the saturating error counter (at most +1 per cycle)
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_labelOut   <= 8'h00;
         r_labelValid <= 1'b0;
         r_errCnt     <= 8'h00;
      end else begin
         r_labelValid <= w_labelLoad;
         if (w_labelLoad) r_labelOut <= r_arg;
         if (w_errEvent && (r_errCnt != 8'hFF)) r_errCnt <= r_errCnt + 8'h01;
      end
   end

   assign io_bus.rx_ready = r_rxReady;
   assign io_bus.tx_data  = w_txData;
   assign io_bus.tx_valid = w_txValid;
   assign o_label_out     = r_labelOut;
   assign o_label_valid   = r_labelValid;
   assign o_err_cnt       = r_errCnt;

endmodule

// File: tb/tb_uart_nids_link.sv
// Directed and randomized bench for uart_nids_link; expected TX frames, labels and
// error counts come from a frame-level reference model kept in this file.
`timescale 1ns/1ps

module tb_uart_nids_link;

   localparam int         TIMEOUT = 100;
   localparam logic [7:0] SYNC    = 8'hA5;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       alertIn = 1'b0;
   logic [7:0] alertCode = 8'h00;
   logic [7:0] labelOut;
   logic       labelValid;
   logic [7:0] errCnt;

   uart_nids_link_if bus ();

   uart_nids_link #(
      .TIMEOUT_CYC (TIMEOUT),
      .SYNC_BYTE   (SYNC)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rstN),
      .io_bus        (bus.slave),
      .i_alert_in    (alertIn),
      .i_alert_code  (alertCode),
      .o_label_out   (labelOut),
      .o_label_valid (labelValid),
      .o_err_cnt     (errCnt)
   );

   always #5 clk = ~clk;

   int         nCompared = 0;
   int         nMismatched = 0;
   logic [7:0] expTx[$];
   logic [7:0] gotTx[$];
   int         labelPulses = 0;
   int         expPulses = 0;
   logic [7:0] expLabel = 8'h00;
   int         expErr = 0;

   // Capture every completed TX handshake and every label pulse away from the edge
   always @(negedge clk) begin
      if (rstN && bus.tx_valid && bus.tx_ready) gotTx.push_back(bus.tx_data);
      if (labelValid) labelPulses++;
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick(1);
      bus.rx_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
      applyStimulus(SYNC);
      applyStimulus(cmd);
      applyStimulus(arg);
      applyStimulus(chk);
   endtask

   // Reference model: a whole outgoing frame, checksum derived from the frame rule
   task automatic pushFrame(input logic [7:0] b1, input logic [7:0] b2);
      expTx.push_back(SYNC);
      expTx.push_back(b1);
      expTx.push_back(b2);
      expTx.push_back(SYNC ^ b1 ^ b2);
   endtask

   task automatic bumpErr();
      if (expErr < 255) expErr++;
   endtask

   task automatic modelFrame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
      if (chk != (SYNC ^ cmd ^ arg)) begin
         pushFrame(8'h15, 8'h01);
         bumpErr();
      end else if (cmd == 8'h4C) begin
         expLabel = arg;
         expPulses++;
         pushFrame(8'h06, 8'h4C);
      end else if (cmd == 8'h50) begin
         pushFrame(8'h50, arg);
      end else begin
         pushFrame(8'h15, 8'h02);
         bumpErr();
      end
   endtask

   task automatic checkTx(input string tag, input int budget);
      int cyc = 0;
      while (gotTx.size() < expTx.size() && cyc < budget) begin
         tick(1);
         cyc++;
      end
      tick(8);
      checkOutput($sformatf("%s tx count", tag), gotTx.size(), expTx.size());
      for (int i = 0; i < expTx.size() && i < gotTx.size(); i++) begin
         checkOutput($sformatf("%s tx byte %0d", tag, i), gotTx[i], expTx[i]);
      end
      expTx.delete();
      gotTx.delete();
   endtask

   task automatic checkState(input string tag);
      checkOutput($sformatf("%s label_out", tag), labelOut, expLabel);
      checkOutput($sformatf("%s label pulses", tag), labelPulses, expPulses);
      checkOutput($sformatf("%s err_cnt", tag), errCnt, expErr);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput($sformatf("%s rx_ready", tag), bus.rx_ready, 0);
      checkOutput($sformatf("%s tx_valid", tag), bus.tx_valid, 0);
      checkOutput($sformatf("%s tx_data", tag), bus.tx_data, 0);
      checkOutput($sformatf("%s label_out", tag), labelOut, 0);
      checkOutput($sformatf("%s label_valid", tag), labelValid, 0);
      checkOutput($sformatf("%s err_cnt", tag), errCnt, 0);
   endtask

   initial begin
      logic [7:0] cmd;
      logic [7:0] arg;
      logic [7:0] chk;
      logic [7:0] junk;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;

      rstN = 1'b0;
      tick(3);
      checkResetValues("reset");
      rstN = 1'b1;
      tick(1);
      checkOutput("rx_ready after reset", bus.rx_ready, 1);

      // Label frame after a junk byte, with exact response latency
      applyStimulus(8'h33);
      applyStimulus(SYNC);
      applyStimulus(8'h4C);
      applyStimulus(8'h07);
      applyStimulus(8'hEE);
      checkOutput("label_valid pulse", labelValid, 1);
      checkOutput("label_out value", labelOut, 8'h07);
      checkOutput("tx_valid before latency", bus.tx_valid, 0);
      expLabel = 8'h07;
      expPulses++;
      pushFrame(8'h06, 8'h4C);
      tick(1);
      checkOutput("tx_valid at latency", bus.tx_valid, 1);
      checkOutput("tx_data at latency", bus.tx_data, SYNC);

      // Alert raised while the ACK is on the wire goes out right after it
      alertCode = 8'h2A;
      alertIn   = 1'b1;
      pushFrame(8'h41, 8'h2A);
      tick(2);
      alertIn = 1'b0;
      checkTx("ack+alert", 40);
      checkState("ack+alert");

      $display("[TB] bad checksum, ping, unknown command, A5 as data");
      sendFrame(8'h4C, 8'h07, 8'h00);
      modelFrame(8'h4C, 8'h07, 8'h00);
      checkTx("bad chk", 40);
      checkState("bad chk");
      sendFrame(8'h50, 8'h3C, 8'hC9);
      modelFrame(8'h50, 8'h3C, 8'hC9);
      sendFrame(8'h99, 8'h00, 8'h3C);
      modelFrame(8'h99, 8'h00, 8'h3C);
      checkTx("ping+unknown", 60);
      checkState("ping+unknown");
      sendFrame(8'h4C, SYNC, SYNC ^ 8'h4C ^ SYNC);
      modelFrame(8'h4C, SYNC, SYNC ^ 8'h4C ^ SYNC);
      checkTx("sync as data", 40);
      checkState("sync as data");

      $display("[TB] inter-byte timeout");
      applyStimulus(SYNC);
      applyStimulus(8'h4C);
      tick(90);
      checkOutput("err before timeout", errCnt, expErr);
      tick(15);
      bumpErr();
      checkOutput("err after timeout", errCnt, expErr);
      sendFrame(8'h4C, 8'h5E, SYNC ^ 8'h4C ^ 8'h5E);
      modelFrame(8'h4C, 8'h5E, SYNC ^ 8'h4C ^ 8'h5E);
      checkTx("after timeout", 40);
      checkState("after timeout");

      $display("[TB] alert and response in the same cycle");
      alertCode = 8'h3C;
      applyStimulus(SYNC);
      applyStimulus(8'h50);
      applyStimulus(8'h77);
      alertIn = 1'b1;
      applyStimulus(SYNC ^ 8'h50 ^ 8'h77);
      pushFrame(8'h41, 8'h3C);
      pushFrame(8'h50, 8'h77);
      tick(2);
      alertIn = 1'b0;
      checkTx("simultaneous", 60);
      checkState("simultaneous");

      $display("[TB] TX stall with repeated alert edges");
      bus.tx_ready = 1'b0;
      alertCode = 8'h11;
      alertIn   = 1'b1;
      tick(2);
      alertIn = 1'b0;
      tick(2);
      alertCode = 8'h22;
      alertIn   = 1'b1;
      tick(2);
      alertIn = 1'b0;
      tick(2);
      alertCode = 8'h33;
      alertIn   = 1'b1;
      tick(2);
      alertIn = 1'b0;
      bumpErr();
      tick(50);
      checkOutput("stall tx_valid", bus.tx_valid, 1);
      checkOutput("stall tx_data", bus.tx_data, SYNC);
      checkOutput("stall err_cnt", errCnt, expErr);
      bus.tx_ready = 1'b1;
      pushFrame(8'h41, 8'h11);
      pushFrame(8'h41, 8'h22);
      checkTx("stall alerts", 60);
      checkState("stall alerts");

      $display("[TB] response slot overflow");
      bus.tx_ready = 1'b0;
      sendFrame(8'h50, 8'h01, SYNC ^ 8'h50 ^ 8'h01);
      sendFrame(8'h50, 8'h02, SYNC ^ 8'h50 ^ 8'h02);
      sendFrame(8'h50, 8'h03, SYNC ^ 8'h50 ^ 8'h03);
      bumpErr();
      tick(2);
      checkOutput("overflow err_cnt", errCnt, expErr);
      bus.tx_ready = 1'b1;
      pushFrame(8'h50, 8'h01);
      pushFrame(8'h50, 8'h02);
      checkTx("overflow", 60);
      checkState("overflow");

      $display("[TB] randomized frames");
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h00;
            applyStimulus(junk);
         end
         case ($urandom_range(0, 3))
            0, 1:    cmd = 8'h4C;
            2:       cmd = 8'h50;
            default: cmd = 8'($urandom);
         endcase
         arg = 8'($urandom);
         chk = SYNC ^ cmd ^ arg;
         if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         sendFrame(cmd, arg, chk);
         modelFrame(cmd, arg, chk);
         checkTx($sformatf("random %0d", n), 40);
         checkState($sformatf("random %0d", n));
      end

      $display("[TB] error counter saturation");
      bus.tx_ready = 1'b0;
      for (int n = 0; n < 260; n++) begin
         sendFrame(8'h99, 8'h00, SYNC ^ 8'h99);
         bumpErr();
      end
      tick(2);
      checkOutput("saturated err_cnt", errCnt, 255);
      bus.tx_ready = 1'b1;
      pushFrame(8'h15, 8'h02);
      pushFrame(8'h15, 8'h02);
      checkTx("saturation", 60);
      checkState("saturation");

      $display("[TB] reset mid-frame");
      bus.tx_ready = 1'b0;
      sendFrame(8'h50, 8'hAA, SYNC ^ 8'h50 ^ 8'hAA);
      applyStimulus(SYNC);
      applyStimulus(8'h4C);
      rstN = 1'b0;
      tick(1);
      checkResetValues("mid-frame reset");
      rstN = 1'b1;
      bus.tx_ready = 1'b1;
      expErr   = 0;
      expLabel = 8'h00;
      expTx.delete();
      gotTx.delete();
      tick(1);
      sendFrame(8'h4C, 8'h3C, SYNC ^ 8'h4C ^ 8'h3C);
      modelFrame(8'h4C, 8'h3C, SYNC ^ 8'h4C ^ 8'h3C);
      checkTx("after reset", 40);
      checkState("after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
